// File: rtl/clk_disp_pkg.sv
// rtl/clk_disp_pkg.sv - shared constants for the clock display scanner
// Segment patterns are logical active-high, bit order {g,f,e,d,c,b,a}.
// Digit indices follow the an[] bit order, seconds ones first.
package clk_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [7:0] SEG_DP   = 8'h80;

  localparam logic [2:0] DIG_SEC_O  = 3'd0;
  localparam logic [2:0] DIG_SEC_T  = 3'd1;
  localparam logic [2:0] DIG_MIN_O  = 3'd2;
  localparam logic [2:0] DIG_MIN_T  = 3'd3;
  localparam logic [2:0] DIG_HOUR_O = 3'd4;
  localparam logic [2:0] DIG_HOUR_T = 3'd5;

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - BCD nibble to 7-segment pattern decoder
// Ports:
//   bcd_i  in  4  BCD digit; values above 9 render as a dash
//   seg_o  out 7  logical active-high pattern {g,f,e,d,c,b,a}
module bcd7seg
  import clk_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clk_disp_scan.sv
// rtl/clk_disp_scan.sv - six-digit multiplexed 7-segment scanner for HH:MM:SS
// Ports:
//   clk         in  1  system clock
//   rst         in  1  asynchronous active-high reset
//   hour_bcd    in  8  hours, packed BCD {tens,ones}
//   min_bcd     in  8  minutes, packed BCD
//   sec_bcd     in  8  seconds, packed BCD
//   blink_mask  in  3  {hours,minutes,seconds}; 1 = field blinks
//   lz_blank    in  1  blank hour tens digit when it is 0
//   disp_en     in  1  0 = all digits dark (scan keeps running)
//   seg         out 8  {dp,g,f,e,d,c,b,a}, registered
//   an          out 6  digit select, an[0] = sec ones .. an[5] = hour tens
module clk_disp_scan
  import clk_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [2:0] blink_mask,
  input  logic       lz_blank,
  input  logic       disp_en,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW}};
  localparam logic [5:0] AN_INV  = {6{AN_ACTIVE_LOW}};

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             phase_q, phase_d;
  logic [7:0]       hour_sh_q, hour_sh_d;
  logic [7:0]       min_sh_q, min_sh_d;
  logic [7:0]       sec_sh_q, sec_sh_d;
  logic [7:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic [3:0] nibble;
  logic       field_blink;
  logic       dp_on;
  logic       dark;
  logic [6:0] pattern;

  assign tick      = (div_q == DIV_MAX);
  assign frame_end = tick && (idx_q == DIG_HOUR_T);

  bcd7seg u_bcd7seg (
    .bcd_i (nibble),
    .seg_o (pattern)
  );

  // Select the digit being shown this slot and the attributes tied to it.
  always_comb begin
    nibble      = 4'd0;
    field_blink = 1'b0;
    dp_on       = 1'b0;
    case (idx_q)
      DIG_SEC_O: begin
        nibble      = sec_sh_q[3:0];
        field_blink = blink_mask[0];
      end
      DIG_SEC_T: begin
        nibble      = sec_sh_q[7:4];
        field_blink = blink_mask[0];
      end
      DIG_MIN_O: begin
        nibble      = min_sh_q[3:0];
        field_blink = blink_mask[1];
        dp_on       = 1'b1;
      end
      DIG_MIN_T: begin
        nibble      = min_sh_q[7:4];
        field_blink = blink_mask[1];
      end
      DIG_HOUR_O: begin
        nibble      = hour_sh_q[3:0];
        field_blink = blink_mask[2];
        dp_on       = 1'b1;
      end
      DIG_HOUR_T: begin
        nibble      = hour_sh_q[7:4];
        field_blink = blink_mask[2];
      end
      default: begin
        nibble      = 4'd0;
        field_blink = 1'b0;
      end
    endcase
  end

  assign dark = !disp_en
             || (field_blink && phase_q)
             || ((idx_q == DIG_HOUR_T) && lz_blank && (hour_sh_q[7:4] == 4'd0))
             || (idx_q > DIG_HOUR_T);

  always_comb begin
    div_d       = tick ? '0 : div_q + 1'b1;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    hour_sh_d   = hour_sh_q;
    min_sh_d    = min_sh_q;
    sec_sh_d    = sec_sh_q;

    if (tick) begin
      idx_d = (idx_q == DIG_HOUR_T) ? DIG_SEC_O : idx_q + 3'd1;
    end

    // Shadow loads only at the frame boundary so a frame never mixes two times.
    if (frame_end) begin
      hour_sh_d = hour_bcd;
      min_sh_d  = min_bcd;
      sec_sh_d  = sec_bcd;
      if (frame_cnt_q == FRM_MAX) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (dark) begin
      seg_d = SEG_INV;
      an_d  = AN_INV;
    end else begin
      seg_d = ({1'b0, pattern} | (dp_on ? SEG_DP : 8'h00)) ^ SEG_INV;
      an_d  = (6'b000001 << idx_q) ^ AN_INV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= DIG_SEC_O;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
      hour_sh_q   <= 8'h00;
      min_sh_q    <= 8'h00;
      sec_sh_q    <= 8'h00;
      seg_q       <= SEG_INV;
      an_q        <= AN_INV;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      hour_sh_q   <= hour_sh_d;
      min_sh_q    <= min_sh_d;
      sec_sh_q    <= sec_sh_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
